// File: rtl/sd_init_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_init_seq_if
// Brief    : Command/response bus between the SD init sequencer and the shifter
// Revision : 1.0
// ============================================================================
interface sd_init_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        resp_valid;
  logic [7:0]  resp_byte;

  modport master (
    output cmd_valid, cmd_index, cmd_arg, cmd_crc,
    input  cmd_ready, resp_valid, resp_byte
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, cmd_crc,
    output cmd_ready, resp_valid, resp_byte
  );
endinterface
`default_nettype wire

// File: rtl/sd_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : sd_init_seq
// Brief    : SD SPI-mode init sequencer (CMD0, CMD8, CMD55/ACMD41 loop, CMD16)
// Revision : 1.0
// ============================================================================
module sd_init_seq #(
  parameter int CMD0_RETRIES = 8,
  parameter int ACMD41_MAX   = 1000,
  parameter int RESP_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  sd_init_seq_if.master      cmd,
  output logic               busy,
  output logic               init_done,
  output logic               init_error,
  output logic [2:0]         err_code,
  output logic               card_v2
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RESP, S_CHECK, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD16
  } step_t;

  localparam int C0W = $clog2(CMD0_RETRIES + 1);
  localparam int ACW = $clog2(ACMD41_MAX + 1);
  localparam int TOW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [C0W-1:0] C0_LAST = C0W'(CMD0_RETRIES - 1);
  localparam logic [ACW-1:0] AC_LAST = ACW'(ACMD41_MAX - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(RESP_TIMEOUT - 1);

  state_t         state_q;
  step_t          step_q;
  logic           cmd_valid_q;
  logic [7:0]     resp_q;
  logic [C0W-1:0] cmd0_cnt_q;
  logic [ACW-1:0] acmd_cnt_q;
  logic [TOW-1:0] tmo_q;
  logic           init_done_q;
  logic           init_error_q;
  logic [2:0]     err_code_q;
  logic           card_v2_q;

  logic [5:0]     idx_d;
  logic [31:0]    arg_d;
  logic [6:0]     crc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      step_q       <= ST_CMD0;
      cmd_valid_q  <= 1'b0;
      resp_q       <= '0;
      cmd0_cnt_q   <= '0;
      acmd_cnt_q   <= '0;
      tmo_q        <= '0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
      err_code_q   <= 3'd0;
      card_v2_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q      <= S_ISSUE;
            step_q       <= ST_CMD0;
            cmd_valid_q  <= 1'b1;
            cmd0_cnt_q   <= '0;
            acmd_cnt_q   <= '0;
            tmo_q        <= '0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            err_code_q   <= 3'd0;
            card_v2_q    <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (cmd.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            tmo_q       <= '0;
            state_q     <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          // A response on the last allowed cycle still beats the timeout.
          if (cmd.resp_valid) begin
            resp_q  <= cmd.resp_byte;
            state_q <= S_CHECK;
          end else if (tmo_q == TO_LAST) begin
            state_q      <= S_ERROR;
            init_error_q <= 1'b1;
            err_code_q   <= 3'd1;
          end else begin
            tmo_q <= tmo_q + TOW'(1);
          end
        end
        S_CHECK: begin
          // Default is to issue the next command; terminal outcomes override below.
          state_q     <= S_ISSUE;
          cmd_valid_q <= 1'b1;
          case (step_q)
            ST_CMD0: begin
              if (resp_q == 8'h01) begin
                step_q <= ST_CMD8;
              end else if (cmd0_cnt_q < C0_LAST) begin
                cmd0_cnt_q <= cmd0_cnt_q + C0W'(1);
              end else begin
                state_q <= S_ERROR; cmd_valid_q <= 1'b0;
                init_error_q <= 1'b1; err_code_q <= 3'd2;
              end
            end
            ST_CMD8: begin
              if (resp_q == 8'h01 || resp_q == 8'h05) begin
                card_v2_q <= (resp_q == 8'h01);
                step_q    <= ST_CMD55;
              end else begin
                state_q <= S_ERROR; cmd_valid_q <= 1'b0;
                init_error_q <= 1'b1; err_code_q <= 3'd3;
              end
            end
            ST_CMD55: begin
              if (resp_q == 8'h00 || resp_q == 8'h01) begin
                step_q <= ST_ACMD41;
              end else begin
                state_q <= S_ERROR; cmd_valid_q <= 1'b0;
                init_error_q <= 1'b1; err_code_q <= 3'd4;
              end
            end
            ST_ACMD41: begin
              if (resp_q == 8'h00) begin
                step_q <= ST_CMD16;
              end else if (resp_q == 8'h01 && acmd_cnt_q < AC_LAST) begin
                acmd_cnt_q <= acmd_cnt_q + ACW'(1);
                step_q     <= ST_CMD55;
              end else begin
                state_q <= S_ERROR; cmd_valid_q <= 1'b0;
                init_error_q <= 1'b1;
                err_code_q   <= (resp_q == 8'h01) ? 3'd5 : 3'd4;
              end
            end
            ST_CMD16: begin
              state_q     <= (resp_q == 8'h00) ? S_DONE : S_ERROR;
              cmd_valid_q <= 1'b0;
              if (resp_q == 8'h00) begin
                init_done_q <= 1'b1;
              end else begin
                init_error_q <= 1'b1; err_code_q <= 3'd6;
              end
            end
            default: begin
              state_q     <= S_IDLE;
              cmd_valid_q <= 1'b0;
            end
          endcase
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Fields decode from the registered step; they read zero whenever no command is offered.
  always_comb begin
    idx_d = 6'd0;
    arg_d = 32'h0000_0000;
    crc_d = 7'h00;
    if (cmd_valid_q) begin
      case (step_q)
        ST_CMD0:   begin idx_d = 6'd0;  arg_d = 32'h0000_0000; crc_d = 7'h4A; end
        ST_CMD8:   begin idx_d = 6'd8;  arg_d = 32'h0000_01AA; crc_d = 7'h43; end
        ST_CMD55:  begin idx_d = 6'd55; arg_d = 32'h0000_0000; crc_d = 7'h32; end
        ST_ACMD41: begin
          idx_d = 6'd41;
          arg_d = card_v2_q ? 32'h4000_0000 : 32'h0000_0000;
          crc_d = card_v2_q ? 7'h3B : 7'h72;
        end
        ST_CMD16:  begin idx_d = 6'd16; arg_d = 32'h0000_0200; crc_d = 7'h0A; end
        default:   begin idx_d = 6'd0;  arg_d = 32'h0000_0000; crc_d = 7'h00; end
      endcase
    end
  end

  assign cmd.cmd_valid = cmd_valid_q & ~reset;
  assign cmd.cmd_index = idx_d;
  assign cmd.cmd_arg   = arg_d;
  assign cmd.cmd_crc   = crc_d;

  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT_RESP) || (state_q == S_CHECK);
  assign init_done  = init_done_q;
  assign init_error = init_error_q;
  assign err_code   = err_code_q;
  assign card_v2    = card_v2_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_init_seq
// Brief    : Directed, table-driven bench for sd_init_seq
// Revision : 1.0
// ============================================================================
module tb_sd_init_seq;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [7:0]  resp;
    int          stall;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, init_done, init_error, card_v2;
  logic [2:0] err_code;

  int   vectors = 0;
  int   miscompares = 0;
  int   xfers = 0;
  vec_t tbl[$];

  sd_init_seq_if bus();

  sd_init_seq #(
    .CMD0_RETRIES (8),
    .ACMD41_MAX   (4),
    .RESP_TIMEOUT (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cmd        (bus),
    .busy       (busy),
    .init_done  (init_done),
    .init_error (init_error),
    .err_code   (err_code),
    .card_v2    (card_v2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) xfers <= xfers + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                     input logic [7:0] resp, input int stall);
    vec_t v;
    v.idx = idx; v.arg = arg; v.crc = crc; v.resp = resp; v.stall = stall;
    tbl.push_back(v);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.cmd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, bus.cmd_valid, 1);
  endtask

  // Offer one command to the bench-side shifter, optionally stalling, then return an R1 byte.
  task automatic issue_cmd(input string name, input vec_t v);
    logic stable;
    int   x0;
    wait_valid(name);
    chk({name, "_idx"}, bus.cmd_index, v.idx);
    chk({name, "_arg"}, bus.cmd_arg, v.arg);
    chk({name, "_crc"}, bus.cmd_crc, v.crc);
    stable = 1'b1;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      if (!(bus.cmd_valid && bus.cmd_index == v.idx && bus.cmd_arg == v.arg && bus.cmd_crc == v.crc))
        stable = 1'b0;
    end
    if (v.stall > 0) chk({name, "_stall_hold"}, stable, 1);
    x0 = xfers;
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    chk({name, "_valid_drop"}, bus.cmd_valid, 0);
    chk({name, "_one_xfer"}, xfers - x0, 1);
    bus.resp_byte  = v.resp;
    bus.resp_valid = 1'b1;
    @(negedge clk);
    bus.resp_valid = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) issue_cmd($sformatf("row%0d", i), tbl[i]);
  endtask

  initial begin
    vec_t v0;
    int   base;
    int   cnt;

    bus.cmd_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_byte  = 8'h00;

    // rows 0-10: v2 card, three busy ACMD41 replies then ready; CMD8 stalled 20 cycles
    add(6'd0,  32'h0000_0000, 7'h4A, 8'h01, 0);
    add(6'd8,  32'h0000_01AA, 7'h43, 8'h01, 20);
    for (int k = 0; k < 3; k++) begin
      add(6'd55, 32'h0000_0000, 7'h32, 8'h01, 0);
      add(6'd41, 32'h4000_0000, 7'h3B, 8'h01, 0);
    end
    add(6'd55, 32'h0000_0000, 7'h32, 8'h01, 0);
    add(6'd41, 32'h4000_0000, 7'h3B, 8'h00, 0);
    add(6'd16, 32'h0000_0200, 7'h0A, 8'h00, 0);
    // rows 11-15: v1 card
    add(6'd0,  32'h0000_0000, 7'h4A, 8'h01, 0);
    add(6'd8,  32'h0000_01AA, 7'h43, 8'h05, 0);
    add(6'd55, 32'h0000_0000, 7'h32, 8'h01, 0);
    add(6'd41, 32'h0000_0000, 7'h72, 8'h00, 0);
    add(6'd16, 32'h0000_0200, 7'h0A, 8'h00, 0);
    // rows 16-25: ACMD41 never ready, limit of 4 pairs
    add(6'd0,  32'h0000_0000, 7'h4A, 8'h01, 0);
    add(6'd8,  32'h0000_01AA, 7'h43, 8'h01, 0);
    for (int k = 0; k < 4; k++) begin
      add(6'd55, 32'h0000_0000, 7'h32, 8'h01, 0);
      add(6'd41, 32'h4000_0000, 7'h3B, 8'h01, 0);
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", init_done, 0);
    chk("rst_error", init_error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_card_v2", card_v2, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_crc", bus.cmd_crc, 0);

    // Normal v2 card
    base = xfers;
    pulse_start();
    chk("v2_busy", busy, 1);
    run_rows(0, 10);
    repeat (2) @(negedge clk);
    chk("v2_done", init_done, 1);
    chk("v2_busy_end", busy, 0);
    chk("v2_card_v2", card_v2, 1);
    chk("v2_error", init_error, 0);
    chk("v2_xfers", xfers - base, 11);

    // v1 card, restarted from DONE
    base = xfers;
    pulse_start();
    chk("v1_done_cleared", init_done, 0);
    chk("v1_card_v2_cleared", card_v2, 0);
    run_rows(11, 15);
    repeat (2) @(negedge clk);
    chk("v1_done", init_done, 1);
    chk("v1_card_v2", card_v2, 0);
    chk("v1_xfers", xfers - base, 5);

    // Response timeout on CMD0
    pulse_start();
    wait_valid("tmo");
    chk("tmo_idx", bus.cmd_index, 0);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    cnt = 0;
    while (!init_error && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_cycles", cnt, 100);
    chk("tmo_err_code", err_code, 1);
    chk("tmo_busy", busy, 0);

    // CMD0 always answered 0xFF
    base = xfers;
    pulse_start();
    chk("c0_error_cleared", init_error, 0);
    v0.idx = 6'd0; v0.arg = 32'h0; v0.crc = 7'h4A; v0.resp = 8'hFF; v0.stall = 0;
    for (int k = 0; k < 8; k++) issue_cmd($sformatf("c0try%0d", k), v0);
    repeat (3) @(negedge clk);
    chk("c0_xfers", xfers - base, 8);
    chk("c0_error", init_error, 1);
    chk("c0_err_code", err_code, 2);
    chk("c0_no_more_valid", bus.cmd_valid, 0);

    // ACMD41 limit
    base = xfers;
    pulse_start();
    run_rows(16, 25);
    repeat (3) @(negedge clk);
    chk("ac_xfers", xfers - base, 10);
    chk("ac_error", init_error, 1);
    chk("ac_err_code", err_code, 5);
    chk("ac_no_more_valid", bus.cmd_valid, 0);

    // Reset while waiting for a response, then a late response
    pulse_start();
    wait_valid("rw");
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_idle_busy", busy, 0);
    chk("rw_error_cleared", init_error, 0);
    bus.resp_byte  = 8'h01;
    bus.resp_valid = 1'b1;
    @(negedge clk);
    bus.resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rw_late_resp_busy", busy, 0);
    chk("rw_late_resp_valid", bus.cmd_valid, 0);

    // Reset drops cmd_valid in the same cycle
    pulse_start();
    chk("rv_valid_before", bus.cmd_valid, 1);
    reset = 1'b1;
    #1;
    chk("rv_valid_dropped", bus.cmd_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("rv_busy", busy, 0);

    // start together with reset: reset wins
    @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("sr_busy", busy, 0);
    chk("sr_valid", bus.cmd_valid, 0);

    // Fresh sequence starts at CMD0 and advances to CMD8
    pulse_start();
    issue_cmd("fresh_cmd0", tbl[0]);
    wait_valid("fresh_next");
    chk("fresh_next_idx", bus.cmd_index, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
